// File: rtl/sorter_pkg.sv
// Shared types and constants for the complex-magnitude fetch sequencer and its consumers.
package sorter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LATCH,
    CALC,
    EMIT,
    DONE
  } fsm_state_t;

  localparam int NUM_BANKS    = 4;
  localparam int BANK_WIDTH   = 2;
  localparam int SAMPLE_WIDTH = 8;
  localparam int MAG_WIDTH    = 2 * SAMPLE_WIDTH;

endpackage

// File: rtl/complex_mag_fetch_if.sv
// Result stream from the magnitude fetcher to the sorter: valid/ready plus tagged |z|^2.
interface complex_mag_fetch_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  m_valid;
  logic                  m_ready;
  logic [2*WIDTH-1:0]    m_mag;
  logic [1:0]            m_bank;
  logic [ADDR_WIDTH-1:0] m_addr;

  modport master (
    output m_valid,
    output m_mag,
    output m_bank,
    output m_addr,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_mag,
    input  m_bank,
    input  m_addr,
    output m_ready
  );
endinterface

// File: rtl/complex_mag_sq.sv
// Combinational |z|^2 = re^2 + im^2 for signed two's complement operands.
module complex_mag_sq #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   re,
  input  logic [WIDTH-1:0]   im,
  output logic [2*WIDTH-1:0] mag
);
  logic signed [2*WIDTH-1:0] re_x;
  logic signed [2*WIDTH-1:0] im_x;
  logic signed [2*WIDTH-1:0] re_sq;
  logic signed [2*WIDTH-1:0] im_sq;

  // Each square is at most 2^(2W-2), so the unsigned sum never exceeds 2^(2W-1).
  always_comb begin
    re_x  = {{WIDTH{re[WIDTH-1]}}, re};
    im_x  = {{WIDTH{im[WIDTH-1]}}, im};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    mag   = $unsigned(re_sq) + $unsigned(im_sq);
  end
endmodule

// File: rtl/complex_mag_fetch.sv
// Scans the four complex-sample banks address by address and streams tagged |z|^2 results.
module complex_mag_fetch
  import sorter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          n_entries,
  output logic [ADDR_WIDTH-1:0]        r_addr,
  input  logic [NUM_BANKS*WIDTH-1:0]   rd_real,
  input  logic [NUM_BANKS*WIDTH-1:0]   rd_imag,
  complex_mag_fetch_if.master          m,
  output logic                         busy,
  output logic                         done
);
  localparam int NW = ADDR_WIDTH + 1;
  localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);

  fsm_state_t state, state_nx;

  logic [NW-1:0]         n_eff;
  logic [NW-1:0]         n_clamp;
  logic [BANK_WIDTH-1:0] bank;
  logic                  last_addr;
  logic                  handshake;

  logic [WIDTH-1:0]      hold_re [NUM_BANKS];
  logic [WIDTH-1:0]      hold_im [NUM_BANKS];
  logic [2*WIDTH-1:0]    mag_c;

  logic                  valid_q;
  logic [2*WIDTH-1:0]    mag_q;
  logic [BANK_WIDTH-1:0] bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  assign n_clamp   = (n_entries > NW'(DEPTH)) ? NW'(DEPTH) : n_entries;
  assign last_addr = ({1'b0, r_addr} == (n_eff - NW'(1)));
  assign handshake = valid_q && m.m_ready;
  assign done      = (state == DONE);

  assign m.m_valid = valid_q;
  assign m.m_mag   = mag_q;
  assign m.m_bank  = bank_q;
  assign m.m_addr  = addr_q;

  complex_mag_sq #(.WIDTH(WIDTH)) u_sq (
    .re  (hold_re[bank]),
    .im  (hold_im[bank]),
    .mag (mag_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (n_clamp == '0) ? DONE : LOAD;
      LOAD:    state_nx = LATCH;
      LATCH:   state_nx = CALC;
      CALC:    state_nx = EMIT;
      EMIT: begin
        if (handshake) begin
          if (bank != LAST_BANK) state_nx = CALC;
          else if (last_addr)    state_nx = DONE;
          else                   state_nx = LOAD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_eff   <= '0;
      r_addr  <= '0;
      bank    <= '0;
      busy    <= 1'b0;
      valid_q <= 1'b0;
      mag_q   <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        hold_re[i] <= '0;
        hold_im[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_eff  <= n_clamp;
            r_addr <= '0;
            busy   <= (n_clamp != '0);
          end
        end
        LATCH: begin
          for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            hold_re[i] <= rd_real[i*WIDTH +: WIDTH];
            hold_im[i] <= rd_imag[i*WIDTH +: WIDTH];
          end
          bank <= '0;
        end
        CALC: begin
          mag_q   <= mag_c;
          bank_q  <= bank;
          addr_q  <= r_addr;
          valid_q <= 1'b1;
        end
        EMIT: begin
          if (handshake) begin
            valid_q <= 1'b0;
            if (bank != LAST_BANK) bank <= bank + BANK_WIDTH'(1);
            else if (!last_addr)   r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_mag_fetch.sv
// Directed bench for complex_mag_fetch: arithmetic vector table plus scan, backpressure and reset sequences.
module tb_complex_mag_fetch;
  localparam int W      = 8;
  localparam int AW     = 3;
  localparam int D      = 8;
  localparam int BUDGET = 2000;

  typedef struct {
    logic [W-1:0]   re;
    logic [W-1:0]   im;
    logic [2*W-1:0] exp_mag;
  } vec_t;

  typedef struct {
    int mag;
    int bank;
    int addr;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   n_entries;
  logic [AW-1:0] r_addr;
  logic [4*W-1:0] rd_real;
  logic [4*W-1:0] rd_imag;
  logic          busy;
  logic          done;

  complex_mag_fetch_if #(.WIDTH(W), .ADDR_WIDTH(AW)) mif ();

  complex_mag_fetch #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_entries (n_entries),
    .r_addr    (r_addr),
    .rd_real   (rd_real),
    .rd_imag   (rd_imag),
    .m         (mif),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] ram_re [4][D];
  logic [W-1:0] ram_im [4][D];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      rd_real[b*W +: W] <= ram_re[b][r_addr];
      rd_imag[b*W +: W] <= ram_im[b][r_addr];
    end
  end

  vec_t vecs [8];
  res_t results [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_mag(input int b, input int a);
    int re, im;
    if (a < 2) return int'(vecs[a*4 + b].exp_mag);
    re = int'($signed(ram_re[b][a]));
    im = int'($signed(ram_im[b][a]));
    return re*re + im*im;
  endfunction

  task automatic check_results(input string tag, input int n);
    check({tag, "_count"}, results.size(), 4*n);
    for (int i = 0; i < results.size() && i < 4*n; i++) begin
      check($sformatf("%s_bank[%0d]", tag, i), results[i].bank, i % 4);
      check($sformatf("%s_addr[%0d]", tag, i), results[i].addr, i / 4);
      check($sformatf("%s_mag[%0d]",  tag, i), results[i].mag, exp_mag(i % 4, i / 4));
    end
  endtask

  // Entered and left at #1 after a rising edge; cycle 1 is the first cycle after the accepting edge.
  task automatic run_scan(input int n, input int pct, input bit do_start, input int mid_start,
                          input bit start_at_done, input int abort_addr,
                          output int done_cyc, output int done_cnt, output bit aborted);
    bit             pend;
    logic [2*W-1:0] h_mag;
    logic [1:0]     h_bank;
    logic [AW-1:0]  h_addr;
    results.delete();
    done_cyc = -1;
    done_cnt = 0;
    aborted  = 1'b0;
    pend     = 1'b0;
    h_mag = '0; h_bank = '0; h_addr = '0;
    if (do_start) begin
      n_entries = (AW+1)'(n);
      start = 1'b1;
      @(posedge clk); #1;
    end
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      start = (cyc == mid_start);
      if (cyc == mid_start) n_entries = (AW+1)'(6);
      if (pend) begin
        check("hold_valid", mif.m_valid, 1);
        check("hold_mag",   mif.m_mag, h_mag);
        check("hold_bank",  mif.m_bank, h_bank);
        check("hold_addr",  mif.m_addr, h_addr);
      end
      if (mif.m_valid && abort_addr >= 0 && mif.m_bank == 2'd0 && int'(mif.m_addr) == abort_addr) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", mif.m_valid, 0);
        check("abort_busy",  busy, 0);
        check("abort_addr",  r_addr, 0);
        check("abort_mag",   mif.m_mag, 0);
        aborted = 1'b1;
        return;
      end
      mif.m_ready = ($urandom_range(0, 99) < pct);
      if (mif.m_valid && mif.m_ready)
        results.push_back('{int'(mif.m_mag), int'(mif.m_bank), int'(mif.m_addr)});
      pend   = mif.m_valid && !mif.m_ready;
      h_mag  = mif.m_mag;
      h_bank = mif.m_bank;
      h_addr = mif.m_addr;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (start_at_done) start = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    $display("FAIL scan_timeout: got no done within %0d cycles, expected done", BUDGET);
    n_vec++;
    n_err++;
  endtask

  task automatic quiet_after(input string tag);
    @(posedge clk); #1;
    check({tag, "_busy_after"}, busy, 0);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_no_extra_done"}, done, 0);
      if (k < 2) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int dc, dn;
    bit ab;
    vecs[0] = '{8'h80, 8'h80, 16'd32768};
    vecs[1] = '{8'h7F, 8'h80, 16'd32513};
    vecs[2] = '{8'h00, 8'h00, 16'd0};
    vecs[3] = '{8'hFF, 8'h01, 16'd2};
    vecs[4] = '{8'h7F, 8'h7F, 16'd32258};
    vecs[5] = '{8'h80, 8'h00, 16'd16384};
    vecs[6] = '{8'h03, 8'hFC, 16'd25};
    vecs[7] = '{8'hF9, 8'h64, 16'd10049};
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < D; a++) begin
        ram_re[b][a] = W'(a*29 + b*53 + 7);
        ram_im[b][a] = W'(a*71 + b*13 + 200);
      end
    for (int i = 0; i < 8; i++) begin
      ram_re[i%4][i/4] = vecs[i].re;
      ram_im[i%4][i/4] = vecs[i].im;
    end

    rst_n = 1'b0; start = 1'b0; n_entries = '0; mif.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_addr", r_addr, 0);
    check("rst_valid",  mif.m_valid, 0);
    check("rst_mag",    mif.m_mag, 0);
    check("rst_bank",   mif.m_bank, 0);
    check("rst_maddr",  mif.m_addr, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic scan + arithmetic corner table (addresses 0..1 hold the vectors)
    run_scan(2, 100, 1, -1, 0, -1, dc, dn, ab);
    check("basic_done_cnt", dn, 1);
    check("basic_done_cyc", dc, 21);
    check_results("basic", 2);
    quiet_after("basic");

    // Backpressure
    run_scan(3, 30, 1, -1, 0, -1, dc, dn, ab);
    check("bp_done_cnt", dn, 1);
    check_results("bp", 3);
    quiet_after("bp");

    // Zero entries
    run_scan(0, 100, 1, -1, 0, -1, dc, dn, ab);
    check("zero_done_cyc", dc, 1);
    check_results("zero", 0);
    quiet_after("zero");

    // Clamp to DEPTH
    run_scan(15, 100, 1, -1, 0, -1, dc, dn, ab);
    check("clamp_done_cnt", dn, 1);
    check_results("clamp", 8);
    if (results.size() > 0) check("clamp_last_addr", results[results.size()-1].addr, 7);
    quiet_after("clamp");

    // Start mid-scan is ignored, as is the new n_entries
    run_scan(2, 100, 1, 7, 0, -1, dc, dn, ab);
    check("mid_done_cyc", dc, 21);
    check_results("mid", 2);
    quiet_after("mid");

    // Start held from the DONE cycle into the next IDLE cycle
    run_scan(1, 100, 1, -1, 1, -1, dc, dn, ab);
    check("dstart_done_cyc", dc, 11);
    check_results("dstart1", 1);
    @(posedge clk); #1;
    check("dstart_ignored_busy", busy, 0);
    check("dstart_ignored_done", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("dstart_accepted_busy", busy, 1);
    run_scan(1, 100, 0, -1, 0, -1, dc, dn, ab);
    check("dstart2_done_cyc", dc, 11);
    check_results("dstart2", 1);
    quiet_after("dstart2");

    // Reset during EMIT of a2
    run_scan(4, 100, 1, -1, 0, 2, dc, dn, ab);
    check("abort_taken", ab, 1);
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_done",  done, 0);
      check("abort_no_valid", mif.m_valid, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle_done", done, 0);
    run_scan(2, 100, 1, -1, 0, -1, dc, dn, ab);
    check("rescan_done_cyc", dc, 21);
    check_results("rescan", 2);
    quiet_after("rescan");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
